// File: rtl/systolic_pkg.sv
// Shared types, default parameters and lane slice/pack helpers for the N x N systolic matmul engine.
package systolic_pkg;

    localparam int unsigned DEF_N      = 4;
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_ACC_W  = 32;
    localparam int unsigned DEF_K_MAX  = 255;

    // Upper bounds for the generic lane helpers
    localparam int unsigned LANE_MAX_W = 64;
    localparam int unsigned BUS_MAX_W  = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } sa_state_e;

    function automatic logic [LANE_MAX_W-1:0] lane_mask(input int unsigned w);
        return (w >= LANE_MAX_W) ? '1 : ((LANE_MAX_W'(1) << w) - LANE_MAX_W'(1));
    endfunction

    function automatic logic [LANE_MAX_W-1:0] lane_get(input logic [BUS_MAX_W-1:0] bus,
                                                       input int unsigned idx,
                                                       input int unsigned w);
        logic [BUS_MAX_W-1:0] sh;
        sh = bus >> (idx * w);
        return sh[LANE_MAX_W-1:0] & lane_mask(w);
    endfunction

    function automatic logic [BUS_MAX_W-1:0] lane_put(input logic [BUS_MAX_W-1:0] bus,
                                                      input int unsigned idx,
                                                      input int unsigned w,
                                                      input logic [LANE_MAX_W-1:0] val);
        logic [BUS_MAX_W-1:0] m;
        logic [BUS_MAX_W-1:0] v;
        m = BUS_MAX_W'(lane_mask(w)) << (idx * w);
        v = BUS_MAX_W'(val & lane_mask(w)) << (idx * w);
        return (bus & ~m) | v;
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// One output-stationary MAC cell: forwards A right and B down, accumulates the signed product.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] a_o,
    output logic [DATA_W-1:0] b_o,
    output logic [ACC_W-1:0]  acc_o
);

    logic signed [2*DATA_W-1:0] prod_c;
    logic [DATA_W-1:0]          a_q, b_q;
    logic [ACC_W-1:0]           acc_q, acc_d;

    assign prod_c = $signed(a_i) * $signed(b_i);

    // Accumulator wraps modulo 2^ACC_W; the product is sign-extended first
    always_comb begin
        acc_d = clr_i ? '0 : acc_q + ACC_W'(prod_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_i;
            b_q   <= b_i;
            acc_q <= acc_d;
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign acc_o = acc_q;

endmodule

// File: rtl/systolic_matmul_nxn.sv
// N x N output-stationary systolic C = A*B with internal skew, run control and row readout.
// Optional feature macro SYSTOLIC_ACC_EN: start with acc=1 keeps previous C (C <- C + A*B).
module systolic_matmul_nxn
    import systolic_pkg::*;
#(
    parameter  int unsigned N      = DEF_N,
    parameter  int unsigned DATA_W = DEF_DATA_W,
    parameter  int unsigned ACC_W  = DEF_ACC_W,
    parameter  int unsigned K_MAX  = DEF_K_MAX,
    localparam int unsigned KW     = $clog2(K_MAX + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [KW-1:0]         k_len,
    input  logic                  acc,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*DATA_W-1:0]   a_vec,
    input  logic [N*DATA_W-1:0]   b_vec,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [$clog2(N)-1:0]  out_row,
    output logic [N*ACC_W-1:0]    out_data,
    output logic                  done
);

    localparam int unsigned RW = $clog2(N);
    localparam int unsigned DW = $clog2(2 * N);

    sa_state_e         state_q, state_d;
    logic [KW-1:0]     k_q, k_d, beat_q, beat_d;
    logic [DW-1:0]     drain_q, drain_d;
    logic [RW-1:0]     row_q, row_d;
    logic              done_q, done_d;
    logic              clr_c, beat_fire, acc_keep;

    logic [DATA_W-1:0] a_h [N][N+1];
    logic [DATA_W-1:0] b_v [N+1][N];
    logic [ACC_W-1:0]  acc_w [N][N];

`ifdef SYSTOLIC_ACC_EN
    assign acc_keep = acc;
`else
    logic unused_acc;
    assign unused_acc = acc;
    assign acc_keep   = 1'b0;
`endif

    assign beat_fire = (state_q == LOAD) && in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            beat_q  <= '0;
            drain_q <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            beat_q  <= beat_d;
            drain_q <= drain_d;
            row_q   <= row_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        beat_d  = beat_q;
        drain_d = drain_q;
        row_d   = row_q;
        done_d  = 1'b0;
        clr_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    k_d     = k_len;
                    beat_d  = '0;
                    drain_d = '0;
                    row_d   = '0;
                    clr_c   = ~acc_keep;
                    state_d = (k_len == '0) ? DRAIN : LOAD;
                end
            end
            LOAD: begin
                if (beat_fire) begin
                    beat_d = beat_q + KW'(1);
                    if (beat_q == k_q - KW'(1)) state_d = DRAIN;
                end
            end
            // Long enough for the last beat to reach PE(N-1,N-1)
            DRAIN: begin
                drain_d = drain_q + DW'(1);
                if (drain_q == DW'(2 * N - 2)) state_d = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    if (row_q == RW'(N - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        in_ready  = (state_q == LOAD);
        out_valid = 1'b0;
        out_row   = '0;
        out_data  = '0;
        done      = done_q;
        if (state_q == OUT) begin
            out_valid = 1'b1;
            out_row   = row_q;
            for (int j = 0; j < N; j++) begin
                out_data[j*ACC_W +: ACC_W] = acc_w[row_q][j];
            end
        end
    end

    // Lane i of A / lane j of B enter through a delay line of depth i / j; bubbles inject zeros
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        logic [DATA_W-1:0] a_lane, b_lane;
        assign a_lane = beat_fire ? DATA_W'(lane_get(BUS_MAX_W'(a_vec), gi, DATA_W)) : '0;
        assign b_lane = beat_fire ? DATA_W'(lane_get(BUS_MAX_W'(b_vec), gi, DATA_W)) : '0;

        if (gi == 0) begin : g_direct
            assign a_h[0][0] = a_lane;
            assign b_v[0][0] = b_lane;
        end else begin : g_delay
            logic [DATA_W-1:0] a_dl_q [gi];
            logic [DATA_W-1:0] b_dl_q [gi];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < gi; s++) begin
                        a_dl_q[s] <= '0;
                        b_dl_q[s] <= '0;
                    end
                end else begin
                    a_dl_q[0] <= a_lane;
                    b_dl_q[0] <= b_lane;
                    for (int s = 1; s < gi; s++) begin
                        a_dl_q[s] <= a_dl_q[s-1];
                        b_dl_q[s] <= b_dl_q[s-1];
                    end
                end
            end
            assign a_h[gi][0] = a_dl_q[gi-1];
            assign b_v[0][gi] = b_dl_q[gi-1];
        end

        logic unused_edge;
        assign unused_edge = ^{a_h[gi][N], b_v[N][gi]};
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            systolic_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_pe (
                .clk    (clk),
                .rst    (rst),
                .clr_i  (clr_c),
                .a_i    (a_h[gi][gj]),
                .b_i    (b_v[gi][gj]),
                .a_o    (a_h[gi][gj+1]),
                .b_o    (b_v[gi+1][gj]),
                .acc_o  (acc_w[gi][gj])
            );
        end
    end

endmodule
